mem_arbiter: RTL and testbench

- Shares the single-port node memory (1024 x 8, 16-bit word interface) between up to NUM_REQ client blocks, e.g. amISink, route-table builder and packet handler.
- Round-robin grant with bounded ownership: a client holds the memory for a burst of accesses, then gives it up.
- Drives the memory's address, write-enable and write-data pins.
- Returns read data to clients with a per-client valid strobe.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_rr_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the node-memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH  = 1024;
  localparam int MEM_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    REL  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin priority encoder: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   owner,
  output logic               any_req
);

  always_comb begin
    int unsigned idx;
    owner   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        owner   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded ownership for the single-port node memory,
// with a read-valid delay line matching the memory read latency.
module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH,
  parameter int MAX_HOLD   = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_wr_en,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [WORD_WIDTH-1:0]          rdata,
  output logic [WORD_WIDTH-1:0]          mem_address,
  output logic                           mem_wr_en,
  output logic [WORD_WIDTH-1:0]          mem_data_in,
  input  logic [WORD_WIDTH-1:0]          mem_data_out
);

  import mem_arbiter_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  arb_state_t          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    owner;
  logic [PTR_W-1:0]    pick;
  logic [CNT_W-1:0]    hold_cnt;
  logic                any_req;
  logic                qual;
  logic [NUM_REQ-1:0]  rd_pipe [RD_LATENCY];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .owner   (pick),
    .any_req (any_req)
  );

  assign qual        = gnt[owner] & req[owner];
  assign mem_address = req_addr[owner*WORD_WIDTH +: WORD_WIDTH];
  assign mem_data_in = req_wdata[owner*WORD_WIDTH +: WORD_WIDTH];
  assign mem_wr_en   = qual & req_wr_en[owner];
  assign rvalid      = rd_pipe[RD_LATENCY-1];
  assign rdata       = mem_data_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= pick;
            gnt   <= NUM_REQ'(1) << pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (!qual) begin
            gnt   <= '0;
            state <= REL;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            // the access that hits the limit still completes this cycle
            if (hold_cnt == HOLD_LAST) begin
              gnt   <= '0;
              state <= REL;
            end
          end
        end
        REL: begin
          hold_cnt <= '0;
          ptr      <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // gnt is one-hot on the owner, so it doubles as the per-client read tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= {NUM_REQ{qual & ~req_wr_en[owner]}} & gnt;
      for (int unsigned i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queue-driven clients, behavioural grant model
// and a reference memory predicting every read response.
module tb_mem_arbiter;

  localparam int N        = 4;
  localparam int W        = 16;
  localparam int MAX_HOLD = 16;

  typedef struct packed {
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } acc_t;

  typedef struct packed {
    int           who;
    logic [W-1:0] data;
    int           due;
  } rd_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req, req_wr_en, gnt, rvalid;
  logic [N*W-1:0] req_addr, req_wdata;
  logic [W-1:0]   rdata, mem_address, mem_data_in, mem_data_out;
  logic           mem_wr_en;

  always #5 clock = ~clock;

  mem_arbiter #(
    .NUM_REQ    (N),
    .WORD_WIDTH (W),
    .MAX_HOLD   (MAX_HOLD),
    .RD_LATENCY (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_wr_en    (req_wr_en),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  function automatic logic [W-1:0] init_word(int i);
    return W'((i * 97 + 16'h3C00) ^ (i << 5));
  endfunction

  function automatic logic [N-1:0] oh(int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Synchronous-read memory, one cycle latency
  logic [W-1:0] mem [1024];
  logic [W-1:0] mem_q;
  assign mem_data_out = mem_q;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clock);
      if (mem_wr_en) mem[mem_address[9:0]] <= mem_data_in;
      mem_q <= mem[mem_address[9:0]];
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Client request queues and the scoreboard of expected read responses
  acc_t cq [N][$];
  rd_t  exp_q [$];

  // Behavioural model state
  int m_owner, m_cnt, m_wait, m_ptr;
  logic [W-1:0] ref_mem [1024];

  // Observed grant history
  int grant_log [$];
  int run_log [$];
  int gap_log [$];
  logic [N-1:0] prev_gnt;
  int run_cur, gap_cnt, wr_cycles, busy_seen;

  task automatic m_reset();
    m_owner = -1; m_cnt = 0; m_wait = 0; m_ptr = 0;
    prev_gnt = '0; run_cur = 0; gap_cnt = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() != 0) begin
        req[i]             = 1'b1;
        req_wr_en[i]       = cq[i][0].wr;
        req_addr[i*W +: W] = cq[i][0].addr;
        req_wdata[i*W +: W] = cq[i][0].data;
      end else begin
        req[i]             = 1'b0;
        req_wr_en[i]       = 1'b0;
        req_addr[i*W +: W] = '0;
        req_wdata[i*W +: W] = '0;
      end
    end
  endtask

  task automatic release_owner();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_cnt   = 0;
    m_wait  = 1;
  endtask

  // One cycle at the negedge: compare against the model, then advance it
  task automatic step();
    logic [N-1:0] eg;
    logic q;
    acc_t a;
    @(negedge clock);
    eg = (m_owner >= 0) ? oh(m_owner) : '0;
    chk("gnt", gnt, eg);
    q = (m_owner >= 0) && req[m_owner];
    chk("mem_wr_en", mem_wr_en, q && req_wr_en[m_owner]);

    if (gnt != 0 && prev_gnt == 0) begin
      grant_log.push_back($clog2(gnt));
      gap_log.push_back(gap_cnt);
      run_cur = 0;
    end
    if (gnt == 0) gap_cnt++; else gap_cnt = 0;
    if ((gnt & req) != 0) run_cur++;
    if (gnt == 0 && prev_gnt != 0) run_log.push_back(run_cur);
    prev_gnt = gnt;
    if (mem_wr_en) wr_cycles++;
    if (gnt != 0 || mem_wr_en || rvalid != 0) busy_seen++;

    if (q) begin
      a = cq[m_owner][0];
      chk("mem_address", mem_address, a.addr);
      if (a.wr) begin
        chk("mem_data_in", mem_data_in, a.data);
        ref_mem[a.addr[9:0]] = a.data;
      end else begin
        exp_q.push_back('{who: m_owner, data: ref_mem[a.addr[9:0]], due: cyc + 1});
      end
      m_cnt++;
      if (m_cnt == MAX_HOLD) release_owner();
    end else if (m_owner >= 0) begin
      release_owner();
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (req != 0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          break;
        end
      end
      m_cnt = 0;
    end

    // Clients advance on what they see granted, like real clients would
    for (int i = 0; i < N; i++)
      if (gnt[i] && req[i] && cq[i].size() != 0) void'(cq[i].pop_front());
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      step();
      @(posedge clock);
      #1;
      drive();
    end
  endtask

  task automatic run_until_idle(int limit);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < limit) begin
      busy = (m_owner >= 0) || (m_wait > 0) || (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (cq[i].size() != 0) busy = 1'b1;
      if (busy) begin
        run_cycles(1);
        n++;
      end
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", limit);
    end
  endtask

  task automatic load_reads(int c, int base, int len);
    for (int k = 0; k < len; k++)
      cq[c].push_back('{wr: 1'b0, addr: W'(base + k), data: '0});
  endtask

  task automatic load_random();
    acc_t a;
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() == 0 && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 24)) begin
          a.wr   = ($urandom_range(0, 2) == 0);
          a.addr = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 63));
          a.data = W'($urandom);
          cq[i].push_back(a);
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data
  int rv_seen [N];
  logic [W-1:0] last_rdata [N];
  rd_t mon_e;
  initial for (int i = 0; i < N; i++) rv_seen[i] = 0;
  always @(negedge clock) begin
    if (reset) begin
      if (rvalid != '0) begin
        for (int i = 0; i < N; i++) if (rvalid[i]) rv_seen[i] = rv_seen[i] + 1;
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", rvalid, '0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rvalid_who", rvalid, oh(mon_e.who));
          chk("rvalid_latency", cyc, mon_e.due);
          chk("rdata", rdata, mon_e.data);
          last_rdata[mon_e.who] = rdata;
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("rvalid_missing", rvalid, oh(exp_q[0].who));
        void'(exp_q.pop_front());
      end
    end
  end

  int base_rv;
  int n;

  initial begin
    req = '0; req_wr_en = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    m_reset();
    wr_cycles = 0; busy_seen = 0;

    #2 reset = 1'b0;
    #1;
    chk("reset_gnt", gnt, '0);
    chk("reset_rvalid", rvalid, '0);
    chk("reset_wr_en", mem_wr_en, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive();

    // Single client 0 reads preloaded words 0..2
    grant_log.delete();
    base_rv = rv_seen[0];
    load_reads(0, 0, 3);
    drive();
    run_until_idle(100);
    chk("s1_rvalid_count", rv_seen[0] - base_rv, 3);
    chk("s1_grants", grant_log.size(), 1);
    chk("s1_owner", grant_log[0], 0);

    // Clients 1 and 3 contend twice
    grant_log.delete();
    load_reads(1, 20, 3);
    load_reads(3, 30, 3);
    drive();
    run_until_idle(100);
    load_reads(1, 40, 2);
    load_reads(3, 50, 2);
    drive();
    run_until_idle(100);
    chk("s2_grants", grant_log.size(), 4);
    chk("s2_g0", grant_log[0], 1);
    chk("s2_g1", grant_log[1], 3);
    chk("s2_g2", grant_log[2], 1);
    chk("s2_g3", grant_log[3], 3);

    // Client 2 exceeds MAX_HOLD while client 0 waits
    grant_log.delete(); run_log.delete(); gap_log.delete();
    load_reads(2, 100, 40);
    drive();
    run_cycles(3);
    load_reads(0, 200, 4);
    drive();
    run_until_idle(300);
    chk("s3_grants", grant_log.size(), 4);
    chk("s3_g0", grant_log[0], 2);
    chk("s3_g1", grant_log[1], 0);
    chk("s3_g2", grant_log[2], 2);
    chk("s3_g3", grant_log[3], 2);
    chk("s3_run0", run_log[0], MAX_HOLD);
    chk("s3_run1", run_log[1], 4);
    chk("s3_run2", run_log[2], MAX_HOLD);
    chk("s3_run3", run_log[3], 40 - 2 * MAX_HOLD);
    chk("s3_gap", gap_log[1], 2);

    // Write then read back
    wr_cycles = 0;
    base_rv = rv_seen[0];
    cq[0].push_back('{wr: 1'b1, addr: 16'd5, data: 16'h00AB});
    cq[0].push_back('{wr: 1'b0, addr: 16'd5, data: '0});
    drive();
    run_until_idle(100);
    chk("s4_wr_cycles", wr_cycles, 1);
    chk("s4_rvalid_count", rv_seen[0] - base_rv, 1);
    chk("s4_rdata", last_rdata[0], 16'h00AB);

    // Reset mid-burst with a read in flight
    load_reads(0, 10, 8);
    drive();
    n = 0;
    do begin
      run_cycles(1);
      n++;
    end while (!(m_owner == 0 && m_cnt >= 2) && n < 30);
    chk("s5_burst_started", m_cnt >= 2, 1'b1);
    chk("s5_pre_rvalid", rvalid, 4'b0001);
    reset = 1'b0;
    #1;
    chk("s5_gnt", gnt, '0);
    chk("s5_rvalid", rvalid, '0);
    chk("s5_wr_en", mem_wr_en, 1'b0);
    m_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) cq[i].delete();
    drive();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    grant_log.delete();
    load_reads(3, 300, 2);
    load_reads(2, 310, 2);
    load_reads(1, 320, 2);
    drive();
    run_until_idle(100);
    chk("s5_first_grant", grant_log[0], 1);

    // Idle
    busy_seen = 0;
    run_cycles(10);
    chk("s6_idle", busy_seen, 0);

    // Random traffic
    repeat (1500) begin
      step();
      @(posedge clock);
      #1;
      load_random();
      drive();
    end
    run_until_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
